// File: rtl/axis_pkt_rr_arb_pkg.sv
// Shared types for the packet round-robin AXI-Stream arbiter.
package axis_pkt_rr_arb_pkg;

  // IDLE: choosing the next source; XFER: one source locked until its tlast.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } arb_state_t;

  localparam int PKT_CNT_W = 16;

endpackage

// File: rtl/axis_skid_reg.sv
// Two-entry FIFO-ordered skid register. Its input ready comes from a flop
// (held count), so the downstream tready never reaches the upstream side
// combinationally.
module axis_skid_reg #(
  parameter int W = 35
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [W-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         push, pop;

  assign s_ready = (count_q != 2'd2);
  assign m_valid = (count_q != 2'd0);
  assign m_data  = mem_q[rd_ptr_q];

  // Next-state: write at wr_ptr on push, advance rd_ptr on pop.
  always_comb begin
    push     = s_valid & s_ready;
    pop      = m_valid & m_ready;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    count_d  = count_q + {1'b0, push} - {1'b0, pop};
    if (push) begin
      mem_d[wr_ptr_q] = s_data;
    end
  end

  // State registers; reset empties the buffer, dropping any partial packet.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/axis_pkt_rr_arb.sv
// Packet-locked round-robin arbiter: shares one AXI-Stream output between
// PORTS packet sources. A grant is chosen in IDLE and held until the granted
// source's tlast beat is accepted, so packets never interleave.
module axis_pkt_rr_arb
  import axis_pkt_rr_arb_pkg::*;
#(
  parameter int   WIDTH      = 32,
  parameter int   PORTS      = 4,
  parameter int   PORTS_BITS = (PORTS <= 2) ? 1 : (PORTS <= 4) ? 2 : (PORTS <= 8) ? 3 : 4,
  parameter logic OUT_REG    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PORTS*WIDTH-1:0] s_rx_tdata,
  input  logic [PORTS-1:0]      s_rx_tvalid,
  input  logic [PORTS-1:0]      s_rx_tlast,
  output logic [PORTS-1:0]      s_rx_tready,
  output logic [WIDTH-1:0]      m_tx_tdata,
  output logic                  m_tx_tvalid,
  output logic                  m_tx_tlast,
  output logic [PORTS_BITS-1:0] m_tx_tid,
  input  logic                  m_tx_tready,
  input  logic [PORTS-1:0]      port_en,
  output logic                  busy,
  output logic [PKT_CNT_W-1:0]  pkt_cnt
);

  arb_state_t            state_q, state_d;
  logic [PORTS_BITS-1:0] grant_q, grant_d;
  logic [PORTS_BITS-1:0] last_grant_q, last_grant_d;
  logic [PKT_CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;

  logic [PORTS-1:0]      req;
  logic [WIDTH-1:0]      in_data;
  logic                  in_last;
  logic                  src_valid;
  logic                  in_valid;
  logic                  dn_ready;

  // First requester strictly after 'last', wrapping modulo PORTS.
  function automatic logic [PORTS_BITS-1:0] rr_pick(
    input logic [PORTS-1:0]      r,
    input logic [PORTS_BITS-1:0] last
  );
    logic [PORTS_BITS-1:0] pick;
    logic                  found;
    int                    idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= PORTS; k++) begin
      idx = (int'(last) + k) % PORTS;
      if (!found && r[idx]) begin
        pick  = PORTS_BITS'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Select the granted source's beat.
  always_comb begin
    in_data   = '0;
    in_last   = 1'b0;
    src_valid = 1'b0;
    for (int i = 0; i < PORTS; i++) begin
      if (grant_q == PORTS_BITS'(i)) begin
        in_data   = s_rx_tdata[i*WIDTH +: WIDTH];
        in_last   = s_rx_tlast[i];
        src_valid = s_rx_tvalid[i];
      end
    end
  end

  // Arbitration FSM: next state, grant bookkeeping and upstream ready.
  always_comb begin
    req          = s_rx_tvalid & port_en;
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    pkt_cnt_d    = pkt_cnt_q;
    in_valid     = 1'b0;
    s_rx_tready  = '0;
    case (state_q)
      ST_IDLE: begin
        if (req != '0) begin
          grant_d = rr_pick(req, last_grant_q);
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        in_valid = src_valid;
        for (int i = 0; i < PORTS; i++) begin
          s_rx_tready[i] = (grant_q == PORTS_BITS'(i)) && dn_ready;
        end
        if (src_valid && dn_ready && in_last) begin
          last_grant_d = grant_q;
          pkt_cnt_d    = pkt_cnt_q + 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Arbiter registers; port 0 has first priority out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= PORTS_BITS'(PORTS - 1);
      pkt_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      pkt_cnt_q    <= pkt_cnt_d;
    end
  end

  assign busy    = (state_q == ST_XFER);
  assign pkt_cnt = pkt_cnt_q;

  generate
    if (OUT_REG) begin : g_skid
      localparam int SW = WIDTH + 1 + PORTS_BITS;
      logic [SW-1:0] skid_out;

      axis_skid_reg #(.W(SW)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .s_data  ({grant_q, in_last, in_data}),
        .s_valid (in_valid),
        .s_ready (dn_ready),
        .m_data  (skid_out),
        .m_valid (m_tx_tvalid),
        .m_ready (m_tx_tready)
      );

      assign {m_tx_tid, m_tx_tlast, m_tx_tdata} = skid_out;
    end else begin : g_comb
      assign dn_ready    = m_tx_tready;
      assign m_tx_tvalid = in_valid;
      assign m_tx_tdata  = in_data;
      assign m_tx_tlast  = in_last;
      assign m_tx_tid    = grant_q;
    end
  endgenerate

endmodule

// File: tb/tb_axis_pkt_rr_arb.sv
// Randomized scoreboard bench for axis_pkt_rr_arb (WIDTH=32, PORTS=4, OUT_REG=1).
// Sources behave like packet FIFOs; a packet-level round-robin model predicts
// the order of packets on both the input and output sides.
module tb_axis_pkt_rr_arb;

  localparam int W  = 32;
  localparam int P  = 4;
  localparam int PB = 2;

  typedef struct packed { logic [W-1:0] data; logic last; } beat_t;
  typedef struct packed { logic [W-1:0] data; logic last; logic [PB-1:0] tid; } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [P*W-1:0] s_rx_tdata = '0;
  logic [P-1:0]   s_rx_tvalid = '0;
  logic [P-1:0]   s_rx_tlast = '0;
  logic [P-1:0]   s_rx_tready;
  logic [W-1:0]   m_tx_tdata;
  logic           m_tx_tvalid;
  logic           m_tx_tlast;
  logic [PB-1:0]  m_tx_tid;
  logic           m_tx_tready = 1'b1;
  logic [P-1:0]   port_en = '0;
  logic           busy;
  logic [15:0]    pkt_cnt;

  always #5 clk = ~clk;

  axis_pkt_rr_arb #(.WIDTH(W), .PORTS(P), .PORTS_BITS(PB), .OUT_REG(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .s_rx_tdata  (s_rx_tdata),
    .s_rx_tvalid (s_rx_tvalid),
    .s_rx_tlast  (s_rx_tlast),
    .s_rx_tready (s_rx_tready),
    .m_tx_tdata  (m_tx_tdata),
    .m_tx_tvalid (m_tx_tvalid),
    .m_tx_tlast  (m_tx_tlast),
    .m_tx_tid    (m_tx_tid),
    .m_tx_tready (m_tx_tready),
    .port_en     (port_en),
    .busy        (busy),
    .pkt_cnt     (pkt_cnt)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int load_cyc = 0;
  int first_in = -1, last_in = -1, first_out = -1, last_out = -1;
  int ready_mode = 0;
  int drop_cnt [P];
  int mdl_lg = P - 1;
  int mdl_cnt = 0;

  beat_t src_q [P][$];
  beat_t m_q [P][$];
  exp_t  exp_q [$];
  int    exp_in_q [$];

  task automatic chk(input string name, input longint got, input longint want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", name, got, want);
    end
  endtask

  // Source driver: pops handshaken beats, presents queue heads, drives tready.
  always begin : driver
    logic [P-1:0] fire_s;
    @(negedge clk);
    fire_s = s_rx_tvalid & s_rx_tready;
    @(posedge clk);
    cyc = cyc + 1;
    #1;
    for (int i = 0; i < P; i++) begin
      if (fire_s[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      if (src_q[i].size() > 0 && drop_cnt[i] == 0) begin
        s_rx_tvalid[i]        = 1'b1;
        s_rx_tdata[i*W +: W]  = src_q[i][0].data;
        s_rx_tlast[i]         = src_q[i][0].last;
      end else begin
        s_rx_tvalid[i] = 1'b0;
        s_rx_tlast[i]  = 1'b0;
      end
      if (drop_cnt[i] > 0) drop_cnt[i]--;
    end
    case (ready_mode)
      0:       m_tx_tready = 1'b1;
      1:       m_tx_tready = 1'($urandom_range(0, 1));
      default: m_tx_tready = ~m_tx_tready;
    endcase
  end

  // Monitor: input-side ownership and output-side scoreboard.
  always @(negedge clk) begin : monitor
    logic [P-1:0] want;
    exp_t e;
    if (rst) begin
      if (s_rx_tready != '0) begin
        tests++;
        want = '0;
        if (exp_in_q.size() > 0) want[exp_in_q[0]] = 1'b1;
        if (s_rx_tready != want) begin
          fails++;
          $display("FAIL rx_tready: got %b required %b", s_rx_tready, want);
        end
      end
      if ((s_rx_tvalid & s_rx_tready) != '0) begin
        if (exp_in_q.size() > 0) void'(exp_in_q.pop_front());
        if (first_in < 0) first_in = cyc;
        last_in = cyc;
      end
      if (m_tx_tvalid && m_tx_tready) begin
        tests++;
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL out_beat: got tid=%0d data=%h with no beat required", m_tx_tid, m_tx_tdata);
        end else begin
          e = exp_q.pop_front();
          $display("[TB] beat tid=%0d data=%h last=%0b", m_tx_tid, m_tx_tdata, m_tx_tlast);
          if (m_tx_tdata !== e.data || m_tx_tlast !== e.last || m_tx_tid !== e.tid) begin
            fails++;
            $display("FAIL out_beat: got tid=%0d data=%h last=%0b required tid=%0d data=%h last=%0b",
                     m_tx_tid, m_tx_tdata, m_tx_tlast, e.tid, e.data, e.last);
          end
        end
      end
    end
  end

  // Load packets into sources at one instant and predict the service order.
  task automatic load_pkts(input logic [P-1:0] mask, input logic [P-1:0] en,
                           input int npk, input int lmin, input int lmax, input int mode);
    beat_t b;
    exp_t  e;
    int    p, c, len;
    bit    found, more;
    @(negedge clk);
    port_en    = en;
    ready_mode = mode;
    first_in = -1; last_in = -1; first_out = -1; last_out = -1;
    load_cyc = cyc;
    for (int i = 0; i < P; i++) begin
      if (mask[i]) begin
        for (int k = 0; k < npk; k++) begin
          len = $urandom_range(lmin, lmax);
          for (int j = 0; j < len; j++) begin
            b.data = $urandom;
            b.last = (j == len - 1);
            src_q[i].push_back(b);
            m_q[i].push_back(b);
          end
        end
      end
    end
    more = 1'b1;
    p = 0;
    while (more) begin
      found = 1'b0;
      for (int k = 1; k <= P; k++) begin
        c = (mdl_lg + k) % P;
        if (!found && en[c] && m_q[c].size() > 0) begin
          p = c;
          found = 1'b1;
        end
      end
      if (!found) begin
        more = 1'b0;
      end else begin
        do begin
          b = m_q[p].pop_front();
          e.data = b.data;
          e.last = b.last;
          e.tid  = PB'(p);
          exp_q.push_back(e);
          exp_in_q.push_back(p);
        end while (!b.last);
        mdl_lg = p;
        mdl_cnt++;
      end
    end
    for (int i = 0; i < P; i++) m_q[i].delete();
  endtask

  // Wait for everything predicted to drain, then check the packet counter.
  task automatic wait_idle(input int budget);
    int  n;
    bit  done;
    n = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
      done = (exp_q.size() == 0) && !busy && !m_tx_tvalid;
      for (int i = 0; i < P; i++) if (port_en[i] && src_q[i].size() > 0) done = 1'b0;
    end
    chk("drain_timeout", longint'(done), 1);
    chk("pkt_cnt", pkt_cnt, mdl_cnt % 65536);
    chk("busy_idle", busy, 0);
    for (int i = 0; i < P; i++) if (!port_en[i]) src_q[i].delete();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n;
    logic [P-1:0] en;
    for (int i = 0; i < P; i++) drop_cnt[i] = 0;

    repeat (3) @(negedge clk);
    chk("rst_tvalid", m_tx_tvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    chk("rst_rx_tready", s_rx_tready, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Port 2 alone, 4 beats: latency and back-to-back output.
    load_pkts(4'b0100, 4'b1111, 1, 4, 4, 0);
    wait_idle(200);
    chk("lat_in", first_in - load_cyc, 2);
    chk("lat_out", first_out - load_cyc, 3);
    chk("span_out4", last_out - first_out, 3);

    // All ports, 2x 3-beat packets each: strict rotation, one gap per packet.
    load_pkts(4'b1111, 4'b1111, 2, 3, 3, 0);
    wait_idle(400);
    chk("span_in_rr", last_in - first_in, 30);
    chk("span_out_rr", last_out - first_out, 30);

    // Port 2 disabled while everyone requests.
    load_pkts(4'b1111, 4'b1011, 2, 2, 4, 0);
    wait_idle(400);

    // Toggling downstream ready during a 6-beat packet, port 0 waiting.
    load_pkts(4'b1001, 4'b1111, 1, 6, 6, 2);
    wait_idle(400);

    // Single-beat packet on port 0, then port 1 stalls mid-packet.
    load_pkts(4'b0001, 4'b1111, 1, 1, 1, 0);
    wait_idle(100);
    chk("single_beat_in", last_in - first_in, 0);
    load_pkts(4'b0011, 4'b1111, 1, 6, 6, 0);
    n = 0;
    while (src_q[1].size() > 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("stall_setup_timeout", longint'(n < 100), 1);
    drop_cnt[1] = 5;
    port_en = 4'b1101;
    repeat (3) @(negedge clk);
    chk("stall_busy", busy, 1);
    chk("stall_port0_ready", s_rx_tready[0], 0);
    wait_idle(200);

    // Random traffic with random enables and random downstream ready.
    for (int r = 0; r < 6; r++) begin
      en = P'($urandom_range(1, 15));
      load_pkts(en, en, $urandom_range(1, 3), 1, 5, 1);
      wait_idle(1000);
    end

    // Asynchronous reset mid-packet.
    load_pkts(4'b1111, 4'b1111, 2, 8, 8, 0);
    n = 0;
    while (exp_q.size() > 60 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rst_setup_timeout", longint'(n < 200), 1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_tvalid", m_tx_tvalid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_pkt_cnt", pkt_cnt, 0);
    chk("arst_rx_tready", s_rx_tready, 0);
    for (int i = 0; i < P; i++) begin
      src_q[i].delete();
      drop_cnt[i] = 0;
    end
    exp_q.delete();
    exp_in_q.delete();
    mdl_lg = P - 1;
    mdl_cnt = 0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    load_pkts(4'b1111, 4'b1111, 1, 2, 4, 0);
    wait_idle(400);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
